// File: rtl/i2c_slave_regfile.sv
// I2C slave register file: auto-incrementing pointer, write/read bursts, host-side port.
// Optional SCL/SDA 3-sample majority glitch filter enabled by defining I2C_SLV_GLITCH_FILTER_EN.
module i2c_slave_regfile #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter int          NUM_REGS   = 16,
   localparam int         PTR_W      = $clog2(NUM_REGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             scl,
   inout  wire              sda,
   input  logic             host_we,
   input  logic [PTR_W-1:0] host_addr,
   input  logic [7:0]       host_wdata,
   output logic [7:0]       host_rdata,
   output logic             wr_valid,
   output logic [PTR_W-1:0] wr_addr,
   output logic [7:0]       wr_data,
   output logic             busy,
   output logic             done
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, WAIT_STOP
   } state_t;

   state_t           state_reg;
   logic [3:0]       bit_cnt_reg;
   logic [6:0]       rx_reg;
   logic [7:0]       tx_reg;
   logic [PTR_W-1:0] ptr_reg;
   logic             rw_reg;
   logic             sda_oe_reg;

   logic [1:0] scl_sync_reg;
   logic [1:0] sda_sync_reg;
   logic       scl_clean;
   logic       sda_clean;
   logic       scl_prev_reg;
   logic       sda_prev_reg;

   // Reset gates the driver directly so SDA is released without waiting for a clock.
   assign sda = (sda_oe_reg && !rst) ? 1'b0 : 1'bz;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync_reg <= 2'b11;
         sda_sync_reg <= 2'b11;
      end else begin
         scl_sync_reg <= {scl_sync_reg[0], scl};
         sda_sync_reg <= {sda_sync_reg[0], sda};
      end
   end

`ifdef I2C_SLV_GLITCH_FILTER_EN
   logic [1:0] scl_hist_reg;
   logic [1:0] sda_hist_reg;
   logic       scl_filt_reg;
   logic       sda_filt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_hist_reg <= 2'b11;
         sda_hist_reg <= 2'b11;
         scl_filt_reg <= 1'b1;
         sda_filt_reg <= 1'b1;
      end else begin
         scl_hist_reg <= {scl_hist_reg[0], scl_sync_reg[1]};
         sda_hist_reg <= {sda_hist_reg[0], sda_sync_reg[1]};
         scl_filt_reg <= (scl_sync_reg[1] & scl_hist_reg[0]) |
                         (scl_sync_reg[1] & scl_hist_reg[1]) |
                         (scl_hist_reg[0] & scl_hist_reg[1]);
         sda_filt_reg <= (sda_sync_reg[1] & sda_hist_reg[0]) |
                         (sda_sync_reg[1] & sda_hist_reg[1]) |
                         (sda_hist_reg[0] & sda_hist_reg[1]);
      end
   end

   assign scl_clean = scl_filt_reg;
   assign sda_clean = sda_filt_reg;
`else
   assign scl_clean = scl_sync_reg[1];
   assign sda_clean = sda_sync_reg[1];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_prev_reg <= 1'b1;
         sda_prev_reg <= 1'b1;
      end else begin
         scl_prev_reg <= scl_clean;
         sda_prev_reg <= sda_clean;
      end
   end

   logic       scl_rise;
   logic       scl_fall;
   logic       start_det;
   logic       stop_det;
   logic [7:0] rx_byte;
   logic       last_bit;
   logic       i2c_we;
   logic [7:0] ptr_rdata;

   assign scl_rise  = scl_clean & ~scl_prev_reg;
   assign scl_fall  = ~scl_clean & scl_prev_reg;
   assign start_det = scl_clean & scl_prev_reg & sda_prev_reg & ~sda_clean;
   assign stop_det  = scl_clean & scl_prev_reg & ~sda_prev_reg & sda_clean;
   assign rx_byte   = {rx_reg, sda_clean};
   assign last_bit  = scl_rise && (bit_cnt_reg == 4'd7);
   assign i2c_we    = (state_reg == WDATA) && last_bit;

   // Register array kept flat so both the host port and the transmitter can index it.
   logic [NUM_REGS*8-1:0] regs_flat;

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [7:0] data_reg;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            data_reg <= 8'h00;
         end else if (i2c_we && (ptr_reg == PTR_W'(gi))) begin
            data_reg <= rx_byte;
         end else if (host_we && (host_addr == PTR_W'(gi))) begin
            data_reg <= host_wdata;
         end
      end

      assign regs_flat[gi*8 +: 8] = data_reg;
   end

   assign host_rdata = regs_flat[{host_addr, 3'b000} +: 8];
   assign ptr_rdata  = regs_flat[{ptr_reg, 3'b000} +: 8];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         bit_cnt_reg <= 4'd0;
         rx_reg      <= 7'd0;
         tx_reg      <= 8'h00;
         ptr_reg     <= '0;
         rw_reg      <= 1'b0;
         sda_oe_reg  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         wr_valid    <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= 8'h00;
      end else begin
         wr_valid <= 1'b0;
         done     <= 1'b0;
         if (start_det) begin
            state_reg   <= ADDR;
            bit_cnt_reg <= 4'd0;
            sda_oe_reg  <= 1'b0;
         end else if (stop_det) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= 4'd0;
            sda_oe_reg  <= 1'b0;
            done        <= busy;
            busy        <= 1'b0;
         end else begin
            case (state_reg)
               IDLE, WAIT_STOP: begin
               end
               ADDR: begin
                  if (scl_rise) begin
                     rx_reg      <= rx_byte[6:0];
                     bit_cnt_reg <= bit_cnt_reg + 4'd1;
                     if (last_bit) begin
                        bit_cnt_reg <= 4'd0;
                        if (rx_byte[7:1] == SLAVE_ADDR) begin
                           state_reg <= ADDR_ACK;
                           rw_reg    <= rx_byte[0];
                           busy      <= 1'b1;
                        end else begin
                           state_reg <= WAIT_STOP;
                           busy      <= 1'b0;
                        end
                     end
                  end
               end
               // The ACK driver doubles as the phase flag: first fall asserts it, second ends the ACK.
               ADDR_ACK: begin
                  if (scl_fall) begin
                     if (!sda_oe_reg) begin
                        sda_oe_reg <= 1'b1;
                     end else if (rw_reg) begin
                        state_reg   <= RDATA;
                        tx_reg      <= ptr_rdata;
                        sda_oe_reg  <= ~ptr_rdata[7];
                        bit_cnt_reg <= 4'd0;
                     end else begin
                        state_reg  <= PTR;
                        sda_oe_reg <= 1'b0;
                     end
                  end
               end
               PTR: begin
                  if (scl_rise) begin
                     rx_reg      <= rx_byte[6:0];
                     bit_cnt_reg <= bit_cnt_reg + 4'd1;
                     if (last_bit) begin
                        bit_cnt_reg <= 4'd0;
                        ptr_reg     <= rx_byte[PTR_W-1:0];
                        state_reg   <= PTR_ACK;
                     end
                  end
               end
               PTR_ACK, WDATA_ACK: begin
                  if (scl_fall) begin
                     if (!sda_oe_reg) begin
                        sda_oe_reg <= 1'b1;
                     end else begin
                        sda_oe_reg <= 1'b0;
                        state_reg  <= WDATA;
                     end
                  end
               end
               WDATA: begin
                  if (scl_rise) begin
                     rx_reg      <= rx_byte[6:0];
                     bit_cnt_reg <= bit_cnt_reg + 4'd1;
                     if (last_bit) begin
                        bit_cnt_reg <= 4'd0;
                        wr_valid    <= 1'b1;
                        wr_addr     <= ptr_reg;
                        wr_data     <= rx_byte;
                        ptr_reg     <= ptr_reg + 1'b1;
                        state_reg   <= WDATA_ACK;
                     end
                  end
               end
               RDATA: begin
                  if (scl_rise) begin
                     bit_cnt_reg <= bit_cnt_reg + 4'd1;
                     tx_reg      <= {tx_reg[6:0], 1'b0};
                     if (bit_cnt_reg == 4'd7) begin
                        ptr_reg <= ptr_reg + 1'b1;
                     end
                  end else if (scl_fall) begin
                     if (bit_cnt_reg == 4'd8) begin
                        sda_oe_reg  <= 1'b0;
                        bit_cnt_reg <= 4'd0;
                        state_reg   <= RD_MACK;
                     end else begin
                        sda_oe_reg <= ~tx_reg[7];
                     end
                  end
               end
               RD_MACK: begin
                  if (scl_rise) begin
                     if (sda_clean) begin
                        state_reg <= WAIT_STOP;
                     end
                  end else if (scl_fall) begin
                     state_reg   <= RDATA;
                     tx_reg      <= ptr_rdata;
                     sda_oe_reg  <= ~ptr_rdata[7];
                     bit_cnt_reg <= 4'd0;
                  end
               end
               default: begin
                  state_reg <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Randomised bench for i2c_slave_regfile: bus-level master tasks, reference register model,
// and a monitor that scoreboards wr_valid and done pulses against queued expectations.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;
   localparam int NUM_REGS = 16;
   localparam int PTR_W    = 4;
   localparam int Q        = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             scl_drv;
   logic             sda_low;
   logic             host_we;
   logic [PTR_W-1:0] host_addr;
   logic [7:0]       host_wdata;
   logic [7:0]       host_rdata;
   logic             wr_valid;
   logic [PTR_W-1:0] wr_addr;
   logic [7:0]       wr_data;
   logic             busy;
   logic             done;
   wire              sda;

   pullup(sda);
   assign sda = sda_low ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   i2c_slave_regfile #(.SLAVE_ADDR(7'h50), .NUM_REGS(NUM_REGS)) dut (
      .clk(clk), .rst(rst), .scl(scl_drv), .sda(sda),
      .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_rdata(host_rdata), .wr_valid(wr_valid), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy), .done(done)
   );

   typedef struct { int addr; int data; } wr_t;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] mregs[NUM_REGS];
   int         mptr;
   wr_t        exp_wr_q[$];
   int         exp_done_q[$];
   logic [7:0] wq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every DUT pulse must match the oldest queued expectation.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (!rst && wr_valid) begin
            if (exp_wr_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL wr_valid_unexpected: got addr=%0h data=%0h expected no write", wr_addr, wr_data);
            end else begin
               e = exp_wr_q.pop_front();
               check("wr_addr", 32'(wr_addr), e.addr);
               check("wr_data", 32'(wr_data), e.data);
            end
         end
         if (!rst && done) begin
            if (exp_done_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL done_unexpected: got done=1 expected 0");
            end else begin
               void'(exp_done_q.pop_front());
               check("done_pulse", 32'(done), 1);
            end
         end
      end
   end

   initial begin
      repeat (100000) @(posedge clk);
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      if (scl_drv == 1'b0) begin
         sda_low = 1'b0; wait_clk(Q); scl_drv = 1'b1; wait_clk(Q);
      end
      sda_low = 1'b1; wait_clk(Q); scl_drv = 1'b0; wait_clk(Q);
   endtask

   task automatic bus_stop();
      sda_low = 1'b1; wait_clk(Q); scl_drv = 1'b1; wait_clk(Q); sda_low = 1'b0; wait_clk(Q);
   endtask

   task automatic bus_bit(input logic b, output logic sampled);
      sda_low = ~b; wait_clk(Q); scl_drv = 1'b1; wait_clk(Q);
      sampled = sda; wait_clk(Q); scl_drv = 1'b0; wait_clk(Q);
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
      bus_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic recv_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bus_bit(1'b1, s);
         d[i] = s;
      end
      bus_bit(~mack, s);
   endtask

   task automatic host_write(input int a, input logic [7:0] d);
      @(negedge clk);
      host_we = 1'b1; host_addr = a[PTR_W-1:0]; host_wdata = d;
      @(negedge clk);
      host_we = 1'b0;
      mregs[a] = d;
      $display("txn host_write reg=%0h data=%0h", a, d);
   endtask

   task automatic host_peek(input int a, output logic [7:0] d);
      host_addr = a[PTR_W-1:0];
      #1;
      d = host_rdata;
   endtask

   task automatic addr_phase(input logic [7:0] a);
      logic ack;
      send_byte(a, ack);
      check("addr_ack", 32'(ack), 1);
      check("busy_addressed", 32'(busy), 1);
   endtask

   // Write burst of wq[] starting at pointer byte p; model applies the auto-increment rule.
   task automatic txn_write(input logic [7:0] p);
      logic ack;
      bus_start();
      addr_phase(8'hA0);
      send_byte(p, ack);
      check("ptr_ack", 32'(ack), 1);
      mptr = int'(p) % NUM_REGS;
      foreach (wq[i]) begin
         mregs[mptr] = wq[i];
         exp_wr_q.push_back('{mptr, int'(wq[i])});
         send_byte(wq[i], ack);
         check("data_ack", 32'(ack), 1);
         mptr = (mptr + 1) % NUM_REGS;
      end
      exp_done_q.push_back(1);
      bus_stop();
      $display("txn write ptr=%0h bytes=%0d", p, wq.size());
   endtask

   task automatic read_bytes(input int n, output logic [7:0] first, output logic [7:0] second);
      logic [7:0] d;
      first = 8'h00; second = 8'h00;
      for (int i = 0; i < n; i++) begin
         recv_byte(i != n - 1, d);
         check("read_data", 32'(d), 32'(mregs[mptr]));
         if (i == 0) first = d;
         if (i == 1) second = d;
         mptr = (mptr + 1) % NUM_REGS;
      end
   endtask

   task automatic txn_read(input logic set_ptr, input logic [7:0] p, input int n,
                           output logic [7:0] first, output logic [7:0] second);
      logic ack;
      bus_start();
      if (set_ptr) begin
         addr_phase(8'hA0);
         send_byte(p, ack);
         check("ptr_ack", 32'(ack), 1);
         mptr = int'(p) % NUM_REGS;
         bus_start();
      end
      addr_phase(8'hA1);
      read_bytes(n, first, second);
      exp_done_q.push_back(1);
      bus_stop();
      $display("txn read set_ptr=%0b ptr=%0h bytes=%0d", set_ptr, p, n);
   endtask

   initial begin
      logic [7:0] d, d2;
      logic       ack, s;
      int         kind, n;

      rst = 1'b1; scl_drv = 1'b1; sda_low = 1'b0;
      host_we = 1'b0; host_addr = '0; host_wdata = 8'h00;
      for (int i = 0; i < NUM_REGS; i++) mregs[i] = 8'h00;
      mptr = 0;
      wait_clk(5);
      rst = 1'b0;
      wait_clk(5);

      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_wr_valid", 32'(wr_valid), 0);
      check("rst_wr_addr", 32'(wr_addr), 0);
      check("rst_wr_data", 32'(wr_data), 0);
      check("rst_sda", 32'(sda), 1);
      for (int i = 0; i < NUM_REGS; i++) begin
         host_peek(i, d);
         check("rst_reg", 32'(d), 0);
      end

      // Basic burst write
      wq = '{8'hA5, 8'h5A};
      txn_write(8'h03);
      host_peek(3, d); check("reg3_a5", 32'(d), 32'hA5);
      host_peek(4, d); check("reg4_5a", 32'(d), 32'h5A);

      // Pointer then repeated-start read
      host_write(7, 8'h3C);
      txn_read(1'b1, 8'h07, 2, d, d2);
      check("rd_byte0_3c", 32'(d), 32'h3C);
      check("rd_byte1_00", 32'(d2), 32'h00);

      // Pointer wrap
      wq = '{8'h11, 8'h22};
      txn_write(8'h0F);
      host_peek(15, d); check("reg15_11", 32'(d), 32'h11);
      host_peek(0, d);  check("reg0_22", 32'(d), 32'h22);

      // Foreign address: no ACK, not busy, no writes
      bus_start();
      send_byte(8'hB0, ack);
      check("nack_foreign", 32'(ack), 0);
      check("busy_foreign", 32'(busy), 0);
      send_byte(8'h99, ack);
      check("nack_foreign_data", 32'(ack), 0);
      bus_stop();
      $display("txn foreign_addr 0xB0");

      // STOP after 5 data bits
      bus_start();
      addr_phase(8'hA0);
      send_byte(8'h05, ack);
      check("ptr_ack", 32'(ack), 1);
      mptr = 5;
      for (int i = 0; i < 5; i++) bus_bit(1'b1, s);
      exp_done_q.push_back(1);
      bus_stop();
      host_peek(5, d); check("partial_unchanged", 32'(d), 32'(mregs[5]));
      $display("txn partial_byte ptr=05");

      // Randomised mix
      for (int t = 0; t < 12; t++) begin
         kind = $urandom_range(0, 3);
         case (kind)
            0: begin
               n = $urandom_range(1, 4);
               wq.delete();
               for (int i = 0; i < n; i++) wq.push_back(8'($urandom_range(0, 255)));
               txn_write(8'($urandom_range(0, 255)));
            end
            1: txn_read(1'b1, 8'($urandom_range(0, 255)), $urandom_range(1, 3), d, d2);
            2: txn_read(1'b0, 8'h00, $urandom_range(1, 2), d, d2);
            default: host_write($urandom_range(0, NUM_REGS - 1), 8'($urandom_range(0, 255)));
         endcase
      end

      // Reset in the middle of a read while the slave is pulling SDA low
      host_write(0, 8'h00);
      host_write(2, 8'h77);
      bus_start();
      addr_phase(8'hA0);
      send_byte(8'h00, ack);
      check("ptr_ack", 32'(ack), 1);
      bus_start();
      addr_phase(8'hA1);
      for (int i = 0; i < 4; i++) bus_bit(1'b1, s);
      check("sda_driven_low", 32'(sda), 0);
      rst = 1'b1;
      #1;
      check("sda_released_on_rst", 32'(sda), 1);
      wait_clk(3);
      rst = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) mregs[i] = 8'h00;
      mptr = 0;
      for (int i = 0; i < 3; i++) bus_bit(1'b0, s);
      check("busy_after_rst", 32'(busy), 0);
      bus_stop();
      $display("txn reset_mid_read");
      for (int i = 0; i < NUM_REGS; i++) begin
         host_peek(i, d);
         check("post_rst_reg", 32'(d), 0);
      end

      wq = '{8'hA5, 8'h5A};
      txn_write(8'h03);
      host_peek(3, d); check("reg3_a5_again", 32'(d), 32'hA5);
      host_peek(4, d); check("reg4_5a_again", 32'(d), 32'h5A);

      wait_clk(10);
      check("wr_q_drained", exp_wr_q.size(), 0);
      check("done_q_drained", exp_done_q.size(), 0);
      for (int i = 0; i < NUM_REGS; i++) begin
         host_peek(i, d);
         check("final_reg", 32'(d), 32'(mregs[i]));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
